exec_alu_stage: RTL and testbench
=================================

Name: exec_alu_stage

Overview:
Execute stage directly downstream of the B-operand shifter. It takes the A operand and the shifted B operand, performs the ALU operation, and registers the result in the C register. It also holds the status flags {N,V,Z}. Single-cycle ops finish one cycle after accept. MUL is an iterative shift-add that takes WIDTH cycles. Valid/ready handshakes on both sides let the controller stall on either end.

Parameters:
WIDTH, 16, datapath width; also the MUL iteration count.

Ports:
clk  input  1  rising-edge clock (the only clock)
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and op are valid
in_ready  output  1  stage can accept this cycle
ain  input  WIDTH  A operand
bin  input  WIDTH  shifted B operand (shifter sout)
op  input  3  000 ADD, 001 SUB, 010 AND, 011 MVN, 100 MUL, 101-111 reserved
load_status  input  1  result updates status when set
out_valid  output  1  c_out holds an untransferred result
out_ready  input  1  consumer takes c_out
c_out  output  WIDTH  C register
status  output  3  {N,V,Z}, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state changes on rising clk only.
- Reset:
  - state=IDLE, c_out=0, status=3'b000, out_valid=0.
  - Iteration count=0, accumulator=0.
  - Reset mid-MUL or mid-HOLD aborts the operation and discards the result.
- States:
  - IDLE: empty.
  - BUSY: MUL in progress.
  - HOLD: result valid.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational from out_ready. in_ready=0 in BUSY.
- Accept = in_valid && in_ready.
  - The stage latches ain, bin, op and load_status.
  - The latched copies are used for the entire operation, so input changes after accept are ignored.
- Single-cycle ops (ADD, SUB, AND, MVN, reserved):
  - The result is written to c_out on the accept edge, and the state becomes HOLD.
  - out_valid is high the cycle after accept (latency 1).
- ADD: ain+bin mod 2^WIDTH.
- SUB: ain-bin mod 2^WIDTH.
- AND: ain&bin.
- MVN: ~bin.
- Reserved ops: result 0.
- MUL:
  - The accept edge clears the accumulator and count and enters BUSY.
  - Each BUSY edge: if bin_l[count], then accumulator += ain_l<<count (truncated to WIDTH); count++.
  - The edge with count==WIDTH-1 writes the final sum to c_out and enters HOLD.
  - out_valid rises WIDTH cycles after accept (16 by default). Result = low WIDTH bits of the product.
- HOLD:
  - out_valid=1. c_out and status stay stable while out_ready=0.
  - out_ready=1 with no accept: transfer, then IDLE.
  - out_ready=1 with an accept in the same cycle: transfer and accept.
    - Single-cycle op: stays in HOLD with the new result (back-to-back throughput of 1 per cycle).
    - MUL: BUSY, out_valid=0.
- Status:
  - Written on the same edge that writes c_out, only if the latched load_status=1. Otherwise it holds its old value indefinitely.
  - Z = (result==0). N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB:
    - ADD: ain[msb]==bin[msb] && res[msb]!=ain[msb].
    - SUB: ain[msb]!=bin[msb] && res[msb]!=ain[msb].
  - V=0 for all other ops.
- in_valid while in_ready=0 is ignored. The producer must hold its inputs until accept.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic[2:0] alu_op_t (ADD, SUB, AND, MVN, MUL).
  - Status bit indices ST_N=2, ST_V=1, ST_Z=0.
  - Default WIDTH=16.
- One combinational sub-module, alu_core: computes ADD/SUB/AND/MVN result plus V.
- exec_alu_stage owns the FSM, MUL iteration, C and status registers, and handshakes.

Test Plan:
- ADD overflow: ain=16'h7FFF, bin=16'h0001, load_status=1 -> next cycle out_valid=1, c_out=16'h8000, status=3'b110.
- SUB zero then hold flags: SUB ain=bin=16'h0005 with load_status=1 -> c_out=0, status=3'b001. Then AND 16'hFF00 & 16'h00FF with load_status=0 -> c_out=0, status stays 3'b001.
- MUL latency: 16'h0003*16'h0005 -> in_ready=0 for 16 cycles, out_valid asserted exactly 16 cycles after accept, c_out=16'h000F. 16'h0100*16'h0100 with load_status=1 -> c_out=0, Z=1, V=0.
- Backpressure and back-to-back:
  - MVN bin=16'h00F0 with out_ready=0 for 5 cycles -> c_out=16'hFF0F stable, in_ready=0.
  - Then raise out_ready with ADD 1+2 presented -> transfer and accept in the same cycle; next cycle c_out=16'h0003.
- Reset mid-MUL: assert reset 8 cycles into a MUL -> next cycle state IDLE, out_valid=0, c_out=0, status=0, in_ready=1. The aborted result never appears.
- Reserved op 3'b111 with load_status=1 -> c_out=0, status=3'b001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Contents: the ALU opcode enumeration, the stage FSM states, the bit
// positions of the {N,V,Z} status flags and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_MVN = 3'b011,
    OP_MUL = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_HOLD = 2'b10
  } stage_state_t;

  localparam int ST_N = 2;
  localparam int ST_V = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU for the execute stage.
// Ports:
//   a, b  : A operand and shifted B operand
//   op    : 3-bit opcode (ADD/SUB/AND/MVN; MUL and reserved codes give 0)
//   res   : result, modulo 2^WIDTH
//   v     : signed overflow, only ever set for ADD and SUB
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    res = '0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        res = sa + sb;
        // Same-sign operands producing an opposite-sign sum.
        v   = (sa[MSB] == sb[MSB]) && (res[MSB] != sa[MSB]);
      end
      OP_SUB: begin
        res = sa - sb;
        // Opposite-sign operands where the difference takes B's sign.
        v   = (sa[MSB] != sb[MSB]) && (res[MSB] != sa[MSB]);
      end
      OP_AND:  res = a & b;
      OP_MVN:  res = ~b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage following the B-operand shifter.
// Accepts A and shifted B with valid/ready, computes the ALU result into the
// C register and optionally updates the {N,V,Z} status register. Single-cycle
// ops complete on the accept edge; MUL runs a WIDTH-cycle shift-add.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready is combinational
//                           from out_ready while a result is held)
//   ain, bin, op          : operands and opcode
//   load_status           : result also updates status
//   out_valid / out_ready : downstream handshake for c_out
//   c_out                 : C register
//   status                : {N,V,Z}
module exec_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [2:0]       op,
  input  logic             load_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [2:0]       status
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  stage_state_t state, state_n;

  logic             accept;
  logic             is_mul;
  logic             last_iter;
  logic [WIDTH-1:0] core_res;
  logic             core_v;

  // Operands latched on accept; only the MUL iteration reads them later.
  logic [WIDTH-1:0] ain_p1;
  logic [WIDTH-1:0] bin_p1;
  logic             ld_p1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic [CW-1:0]    cnt;

  function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic ovf);
    logic [2:0] f;
    f       = '0;
    f[ST_N] = r[WIDTH-1];
    f[ST_V] = ovf;
    f[ST_Z] = (r == '0);
    return f;
  endfunction

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a   (ain),
    .b   (bin),
    .op  (op),
    .res (core_res),
    .v   (core_v)
  );

  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign out_valid = (state == S_HOLD);
  assign last_iter = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));
  assign acc_sum   = acc + (bin_p1[cnt] ? (ain_p1 << cnt) : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = is_mul ? S_BUSY : S_HOLD;
      S_BUSY: if (last_iter) state_n = S_HOLD;
      S_HOLD: begin
        if (accept)         state_n = is_mul ? S_BUSY : S_HOLD;
        else if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---- accept / MUL iteration -> C and status registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      c_out  <= '0;
      status <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      ain_p1 <= ain;
      bin_p1 <= bin;
      ld_p1  <= load_status;
      if (is_mul) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        c_out <= core_res;
        if (load_status) status <= flags(core_res, core_v);
      end
    end else if (state == S_BUSY) begin
      acc <= acc_sum;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        c_out <= acc_sum;
        if (ld_p1) status <= flags(acc_sum, 1'b0);
      end
    end
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
module tb_exec_alu_stage;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [2:0]   op;
  logic         load_status;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c_out;
  logic [2:0]   status;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  exec_alu_stage #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ain         (ain),
    .bin         (bin),
    .op          (op),
    .load_status (load_status),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .c_out       (c_out),
    .status      (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: what the op must produce, from plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic v);
    longint sa, sb, s, lim;
    logic [2*W-1:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    v   = 1'b0;
    case (o)
      3'd0: begin s = sa + sb; r = W'(s); v = (s >= lim) || (s < -lim); end
      3'd1: begin s = sa - sb; r = W'(s); v = (s >= lim) || (s < -lim); end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: begin p = (2*W)'(a) * (2*W)'(b); r = p[W-1:0]; end
      default: r = '0;
    endcase
  endfunction

  // Model state: held result, pending MUL countdown.
  logic         m_valid;
  logic [W-1:0] m_c;
  logic [2:0]   m_st;
  int           m_cd;
  logic [W-1:0] pend_c;
  logic [2:0]   pend_st;
  logic         pend_ld;

  always @(posedge clk) begin : model
    logic [W-1:0] r;
    logic v;
    bit rdy;
    if (reset) begin
      m_valid = 1'b0; m_c = '0; m_st = '0; m_cd = 0;
    end else begin
      rdy = (m_cd == 0) && (!m_valid || out_ready);
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_valid = 1'b1;
          m_c = pend_c;
          if (pend_ld) m_st = pend_st;
        end
      end else if (rdy && in_valid) begin
        ref_op(op, ain, bin, r, v);
        if (op == 3'd4) begin
          pend_c = r; pend_ld = load_status; pend_st = {r[W-1], 1'b0, r == '0};
          m_cd = W; m_valid = 1'b0;
        end else begin
          m_c = r; m_valid = 1'b1;
          if (load_status) m_st = {r[W-1], v, r == '0};
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model in_ready", 32'(in_ready), 32'((m_cd == 0) && (!m_valid || out_ready)));
      chk("model c_out", 32'(c_out), 32'(m_c));
      chk("model status", 32'(status), 32'(m_st));
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ld, input bit rnd_rdy);
    int n;
    bit acc;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; ain = a; bin = b; load_status = ld;
    n = 0; acc = 0;
    while (!acc && n < 200) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL accept timeout: in_ready never high for op %0d", o);
    end
    in_valid = 1'b0;
    ain = W'($urandom); bin = W'($urandom); op = 3'($urandom); load_status = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; ain = '0; bin = '0; op = '0;
    load_status = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    chk_en = 1;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset c_out", 32'(c_out), 32'd0);
    chk("reset status", 32'(status), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // ADD overflow
    send(3'd0, 16'h7FFF, 16'h0001, 1'b1, 0);
    @(negedge clk);
    chk("add ovf out_valid", 32'(out_valid), 32'd1);
    chk("add ovf c_out", 32'(c_out), 32'h8000);
    chk("add ovf status", 32'(status), 32'b110);

    // SUB to zero, then AND without status load
    send(3'd1, 16'h0005, 16'h0005, 1'b1, 0);
    @(negedge clk);
    chk("sub zero c_out", 32'(c_out), 32'h0000);
    chk("sub zero status", 32'(status), 32'b001);
    send(3'd2, 16'hFF00, 16'h00FF, 1'b0, 0);
    @(negedge clk);
    chk("and c_out", 32'(c_out), 32'h0000);
    chk("and keeps status", 32'(status), 32'b001);

    // MUL latency (inputs are scrambled right after accept)
    send(3'd4, 16'h0003, 16'h0005, 1'b0, 0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("mul busy out_valid", 32'(out_valid), 32'd0);
      chk("mul busy in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("mul out_valid", 32'(out_valid), 32'd1);
    chk("mul c_out", 32'(c_out), 32'h000F);
    send(3'd4, 16'h0100, 16'h0100, 1'b1, 0);
    repeat (W + 1) @(negedge clk);
    chk("mul wrap c_out", 32'(c_out), 32'h0000);
    chk("mul wrap status", 32'(status), 32'b001);

    // Backpressure on MVN, then transfer + accept in one cycle
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd3, 16'h1234, 16'h00F0, 1'b0, 0);
    in_valid = 1'b1; op = 3'd0; ain = 16'h0001; bin = 16'h0002; load_status = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mvn hold c_out", 32'(c_out), 32'hFF0F);
      chk("mvn hold out_valid", 32'(out_valid), 32'd1);
      chk("mvn hold in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b c_out", 32'(c_out), 32'h0003);
    chk("b2b out_valid", 32'(out_valid), 32'd1);

    // Reserved opcode
    send(3'd7, 16'hABCD, 16'h1234, 1'b1, 0);
    @(negedge clk);
    chk("reserved c_out", 32'(c_out), 32'h0000);
    chk("reserved status", 32'(status), 32'b001);

    // Reset mid-MUL
    send(3'd4, 16'h0003, 16'h0005, 1'b1, 0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort c_out", 32'(c_out), 32'd0);
    chk("abort status", 32'(status), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    repeat (W + 4) @(negedge clk);
    chk("abort never shows", 32'(out_valid), 32'd0);

    // Mixed traffic with random backpressure, checked by the model
    for (int k = 0; k < 24; k++)
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), 1);
    out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
